// File: rtl/memory_bus_copy_engine_pkg.sv
// Shared constants for the combined text/data memory bus and its copy engine.
package memory_bus_copy_engine_pkg;

  localparam logic [31:0] TEXT_BEGIN = 32'h0000_0000;
  localparam logic [31:0] TEXT_END   = 32'h0000_0FFF;
  localparam logic [31:0] DATA_BEGIN = 32'h0001_0000;
  localparam logic [31:0] DATA_END   = 32'h0001_0FFF;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [3:0]  BYTE_ENABLE_WORD = 4'b1111;

  // Range arithmetic is 2 bits wider than an address so wrap-around stays visible.
  localparam int unsigned RANGE_BITS = 34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } copy_state_e;

  // True when the half-open byte range [lo, hi) sits inside the inclusive window.
  function automatic logic range_within(input logic [RANGE_BITS-1:0] lo,
                                        input logic [RANGE_BITS-1:0] hi,
                                        input logic [31:0]           win_begin,
                                        input logic [31:0]           win_end);
    return (lo >= RANGE_BITS'(win_begin)) &&
           (hi <= (RANGE_BITS'(win_end) + RANGE_BITS'(1)));
  endfunction

endpackage

// File: rtl/memory_bus_range_check.sv
// Combinational check of a base/word-count pair against the text and data windows.
module memory_bus_range_check
  import memory_bus_copy_engine_pkg::*;
#(
  parameter int unsigned COUNT_BITS = 16
) (
  input  logic [31:0]           src_base_i,
  input  logic [31:0]           dst_base_i,
  input  logic [COUNT_BITS-1:0] count_i,
  output logic                  src_ok_o,
  output logic                  dst_ok_o
);

  logic [RANGE_BITS-1:0] span;
  logic [RANGE_BITS-1:0] src_lo;
  logic [RANGE_BITS-1:0] src_hi;
  logic [RANGE_BITS-1:0] dst_lo;
  logic [RANGE_BITS-1:0] dst_hi;

  // Sources may live in either window; destinations only in data.
  always_comb begin
    span     = RANGE_BITS'(count_i) * RANGE_BITS'(WORD_BYTES);
    src_lo   = RANGE_BITS'(src_base_i);
    src_hi   = src_lo + span;
    dst_lo   = RANGE_BITS'(dst_base_i);
    dst_hi   = dst_lo + span;
    src_ok_o = range_within(src_lo, src_hi, TEXT_BEGIN, TEXT_END) ||
               range_within(src_lo, src_hi, DATA_BEGIN, DATA_END);
    dst_ok_o = range_within(dst_lo, dst_hi, DATA_BEGIN, DATA_END);
  end

endmodule

// File: rtl/memory_bus_copy_engine.sv
// Bus initiator that copies a block of words from text/data into the data window,
// sharing the memory bus with the core through bus_grant.
module memory_bus_copy_engine
  import memory_bus_copy_engine_pkg::*;
#(
  parameter int unsigned COUNT_BITS   = 16,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [COUNT_BITS-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  bus_grant,
  output logic [31:0]           address,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic [3:0]            byte_enable,
  output logic [31:0]           write_data,
  input  logic [31:0]           read_data
);

  if (READ_LATENCY > 1) begin : g_bad_read_latency
    $error("memory_bus_copy_engine: READ_LATENCY must be 0 or 1");
  end

  copy_state_e           state_q, state_d;
  logic [31:0]           src_q, src_d;
  logic [31:0]           dst_q, dst_d;
  logic [31:0]           buf_q, buf_d;
  logic [COUNT_BITS-1:0] rem_q, rem_d;
  logic                  src_ok;
  logic                  dst_ok;
  logic                  aligned;

  memory_bus_range_check #(
    .COUNT_BITS (COUNT_BITS)
  ) u_range_check (
    .src_base_i (src_q),
    .dst_base_i (dst_q),
    .count_i    (rem_q),
    .src_ok_o   (src_ok),
    .dst_ok_o   (dst_ok)
  );

  assign aligned = (src_q[1:0] == 2'b00) && (dst_q[1:0] == 2'b00);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

  // Bus strobes follow bus_grant in the same cycle, so a denied cycle is idle.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    buf_d        = buf_q;
    busy         = 1'b0;
    done         = 1'b0;
    error        = 1'b0;
    address      = '0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    byte_enable  = '0;
    write_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = word_count;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (!aligned || !src_ok || !dst_ok) begin
          state_d = ST_ERR;
        end else if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (bus_grant) begin
          address     = src_q;
          read_enable = 1'b1;
          if (READ_LATENCY == 0) begin
            buf_d   = read_data;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (bus_grant) begin
          address     = src_q;
          read_enable = 1'b1;
          buf_d       = read_data;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy = 1'b1;
        if (bus_grant) begin
          address      = dst_q;
          write_enable = 1'b1;
          byte_enable  = BYTE_ENABLE_WORD;
          write_data   = buf_q;
          src_d        = src_q + 32'(WORD_BYTES);
          dst_d        = dst_q + 32'(WORD_BYTES);
          rem_d        = rem_q - COUNT_BITS'(1);
          state_d      = (rem_q == COUNT_BITS'(1)) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        error   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_bus_copy_engine.sv
// Bench for memory_bus_copy_engine: zero- and one-latency builds against a word-level copy model.
module tb_memory_bus_copy_engine;
  import memory_bus_copy_engine_pkg::*;

  localparam int unsigned CB = 16;
  localparam int MEM_WORDS   = 1024;
  localparam int MAX_CYCLES  = 4000;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic          start0 = 1'b0, start1 = 1'b0;
  logic [31:0]   src0 = '0, dst0 = '0, src1 = '0, dst1 = '0;
  logic [CB-1:0] cnt0 = '0, cnt1 = '0;
  logic          busy0, done0, error0, re0, we0;
  logic          busy1, done1, error1, re1, we1;
  logic [3:0]    be0, be1;
  logic [31:0]   addr0, wd0, rd0, addr1, wd1, rd1;
  logic          grant0 = 1'b1;
  logic [1:0]    gmode = 2'd0;
  logic          init_mem = 1'b1;
  logic [31:0]   rd1_q = '0;
  logic          rd1_v = 1'b0;

  logic [31:0] text_mem [MEM_WORDS];
  logic [31:0] dmem     [2][MEM_WORDS];
  logic [31:0] mdata    [2][MEM_WORDS];
  int act   [2] = '{0, 0};
  int viol  [2] = '{0, 0};
  int dones [2] = '{0, 0};
  int n_checks = 0;
  int n_pass   = 0;

  memory_bus_copy_engine #(.COUNT_BITS(CB), .READ_LATENCY(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .src_addr(src0), .dst_addr(dst0),
    .word_count(cnt0), .busy(busy0), .done(done0), .error(error0), .bus_grant(grant0),
    .address(addr0), .read_enable(re0), .write_enable(we0), .byte_enable(be0),
    .write_data(wd0), .read_data(rd0));

  memory_bus_copy_engine #(.COUNT_BITS(CB), .READ_LATENCY(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .src_addr(src1), .dst_addr(dst1),
    .word_count(cnt1), .busy(busy1), .done(done1), .error(error1), .bus_grant(1'b1),
    .address(addr1), .read_enable(re1), .write_enable(we1), .byte_enable(be1),
    .write_data(wd1), .read_data(rd1));

  // Bus slaves: combinational read for build 0; build 1 returns garbage until a read has had a cycle.
  always_comb rd0 = addr0[16] ? dmem[0][addr0[11:2]] : text_mem[addr0[11:2]];
  always_comb rd1 = rd1_v ? rd1_q : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    rd1_q <= addr1[16] ? dmem[1][addr1[11:2]] : text_mem[addr1[11:2]];
    rd1_v <= re1;
  end

  always @(posedge clock) begin
    if (init_mem) begin
      for (int k = 0; k < MEM_WORDS; k++) begin
        dmem[0][k] <= mdata[0][k];
        dmem[1][k] <= mdata[1][k];
      end
    end else begin
      if (we0 && addr0[31:12] == 20'h00010) dmem[0][addr0[11:2]] <= wd0;
      if (we1 && addr1[31:12] == 20'h00010) dmem[1][addr1[11:2]] <= wd1;
    end
  end

  always @(posedge clock) begin
    case (gmode)
      2'd1:    grant0 <= ~grant0;
      2'd2:    grant0 <= 1'($urandom_range(0, 1));
      default: grant0 <= 1'b1;
    endcase
  end

  function automatic int bus_viol(input logic g, input logic re, input logic we,
                                  input logic [3:0] be, input logic [31:0] a);
    int v = 0;
    if (!g && (re || we)) v++;
    if (re && we) v++;
    if (!we && be != 4'h0) v++;
    if (we && be != 4'hF) v++;
    if (we && a[31:12] != 20'h00010) v++;
    return v;
  endfunction

  always @(negedge clock) begin
    act[0]   = act[0] + int'(re0 || we0);
    act[1]   = act[1] + int'(re1 || we1);
    viol[0]  = viol[0] + bus_viol(grant0, re0, we0, be0, addr0);
    viol[1]  = viol[1] + bus_viol(1'b1, re1, we1, be1, addr1);
    dones[0] = dones[0] + int'(done0);
    dones[1] = dones[1] + int'(done1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic get_done(input int i);  return (i == 0) ? done0  : done1;  endfunction
  function automatic logic get_err(input int i);   return (i == 0) ? error0 : error1; endfunction
  function automatic logic get_busy(input int i);  return (i == 0) ? busy0  : busy1;  endfunction
  function automatic logic get_grant(input int i); return (i == 0) ? grant0 : 1'b1;   endfunction

  task automatic drive(input int inst, input logic v, input logic [31:0] s,
                       input logic [31:0] d, input logic [CB-1:0] c);
    if (inst == 0) begin start0 = v; src0 = s; dst0 = d; cnt0 = c; end
    else           begin start1 = v; src1 = s; dst1 = d; cnt1 = c; end
  endtask

  // Reference: accept/reject by window arithmetic, then a word-by-word forward copy.
  task automatic model_cmd(input int inst, input logic [31:0] s, input logic [31:0] d,
                           input logic [CB-1:0] c, output bit ok);
    longint unsigned se, de;
    logic [31:0] a, b, w;
    bit src_ok, dst_ok;
    se = 64'(s) + 64'(c) * 64'd4;
    de = 64'(d) + 64'(c) * 64'd4;
    src_ok = (64'(s) >= 64'(TEXT_BEGIN) && se <= 64'(TEXT_END) + 64'd1) ||
             (64'(s) >= 64'(DATA_BEGIN) && se <= 64'(DATA_END) + 64'd1);
    dst_ok = (64'(d) >= 64'(DATA_BEGIN) && de <= 64'(DATA_END) + 64'd1);
    ok = (s[1:0] == 2'b00) && (d[1:0] == 2'b00) && src_ok && dst_ok;
    if (ok) begin
      for (int k = 0; k < int'(c); k++) begin
        a = s + 32'(4 * k);
        b = d + 32'(4 * k);
        w = a[16] ? mdata[inst][a[11:2]] : text_mem[a[11:2]];
        mdata[inst][b[11:2]] = w;
      end
    end
  endtask

  task automatic mem_cmp(input int inst, input string tag);
    int bad = 0;
    for (int k = 0; k < MEM_WORDS; k++) if (dmem[inst][k] !== mdata[inst][k]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic run_cmd(input string tag, input int inst, input logic [31:0] s,
                         input logic [31:0] d, input logic [CB-1:0] c, input bit poke);
    bit ok;
    int n, busy_n, denied, lat, exp_n, act_b, viol_b, done_b;
    lat = (inst == 0) ? 2 : 3;
    model_cmd(inst, s, d, c, ok);
    act_b = act[inst]; viol_b = viol[inst]; done_b = dones[inst];
    drive(inst, 1'b1, s, d, c);
    @(negedge clock);
    drive(inst, 1'b0, s, d, c);
    n = 1; busy_n = 0; denied = 0;
    while (!get_done(inst) && !get_err(inst) && n < MAX_CYCLES) begin
      if (get_busy(inst)) busy_n++;
      if (n >= 2 && !get_grant(inst)) denied++;
      if (poke && n == 3) drive(inst, 1'b1, s + 32'h40, d + 32'h100, c);
      if (poke && n == 4) drive(inst, 1'b0, s, d, c);
      @(negedge clock);
      n++;
    end
    exp_n = ok ? 2 + lat * int'(c) + denied : 2;
    chk({tag, "/timeout"}, 64'(n >= MAX_CYCLES), 64'd0);
    chk({tag, "/outcome"}, 64'({get_done(inst), get_err(inst), get_busy(inst)}), ok ? 64'd4 : 64'd2);
    chk({tag, "/cycles"}, 64'(n), 64'(exp_n));
    chk({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_n - 1));
    @(negedge clock);
    chk({tag, "/pulse"}, 64'({get_done(inst), get_err(inst), get_busy(inst)}), 64'd0);
    if (poke) repeat (4 * lat * int'(c) + 8) @(negedge clock);
    chk({tag, "/bus_cycles"}, 64'(act[inst] - act_b), ok ? 64'(lat * int'(c)) : 64'd0);
    chk({tag, "/protocol"}, 64'(viol[inst] - viol_b), 64'd0);
    chk({tag, "/done_pulses"}, 64'(dones[inst] - done_b), ok ? 64'd1 : 64'd0);
    mem_cmp(inst, {tag, "/memory"});
  endtask

  function automatic logic [31:0] rand_addr(input bit want_data);
    logic [31:0] a;
    int off;
    off = ($urandom_range(0, 3) == 0) ? MEM_WORDS - int'($urandom_range(1, 3))
                                      : int'($urandom_range(0, MEM_WORDS - 1));
    a = (want_data ? DATA_BEGIN : TEXT_BEGIN) + 32'(off) * 32'd4;
    if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 11) == 0) a = $urandom;
    return a;
  endfunction

  initial begin
    logic [31:0]   s, d;
    logic [CB-1:0] c;
    int            n;
    for (int k = 0; k < MEM_WORDS; k++) begin
      text_mem[k] = $urandom;
      mdata[0][k] = $urandom;
      mdata[1][k] = $urandom;
    end
    text_mem[0] = 32'h1111_1111;
    text_mem[1] = 32'h2222_2222;
    text_mem[2] = 32'h3333_3333;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_ctrl0", 64'({busy0, done0, error0, re0, we0, be0}), 64'd0);
    chk("reset_bus0", {addr0, wd0}, 64'd0);
    chk("reset_ctrl1", 64'({busy1, done1, error1, re1, we1, be1}), 64'd0);
    chk("reset_bus1", {addr1, wd1}, 64'd0);
    init_mem = 1'b0;
    reset_n  = 1'b1;
    @(negedge clock);

    run_cmd("basic", 0, TEXT_BEGIN, DATA_BEGIN + 32'h10, CB'(3), 1'b0);
    gmode = 2'd1;
    run_cmd("alt_grant", 0, TEXT_BEGIN, DATA_BEGIN + 32'h10, CB'(3), 1'b0);
    gmode = 2'd0;
    run_cmd("rej_src_misaligned", 0, DATA_BEGIN + 32'h2, DATA_BEGIN + 32'h100, CB'(2), 1'b0);
    run_cmd("rej_dst_text", 0, TEXT_BEGIN + 32'h20, TEXT_BEGIN, CB'(1), 1'b0);
    run_cmd("rej_dst_overrun", 0, TEXT_BEGIN, DATA_END - 32'h3, CB'(2), 1'b0);
    run_cmd("dst_last_word", 0, TEXT_BEGIN + 32'h8, DATA_END - 32'h3, CB'(1), 1'b0);
    run_cmd("rej_src_wrap", 0, 32'hFFFF_FFFC, DATA_BEGIN, CB'(2), 1'b0);
    run_cmd("zero_count", 0, TEXT_BEGIN, DATA_BEGIN + 32'h40, CB'(0), 1'b0);
    run_cmd("lat1_copy4", 1, TEXT_BEGIN + 32'h40, DATA_BEGIN + 32'h300, CB'(4), 1'b0);
    run_cmd("lat1_data_src", 1, DATA_BEGIN + 32'h300, DATA_BEGIN + 32'h800, CB'(4), 1'b0);

    // Abort during the write of word 2 of 5: only word 1 may land.
    s = TEXT_BEGIN + 32'h80; d = DATA_BEGIN + 32'h200; c = CB'(5);
    drive(0, 1'b1, s, d, c);
    @(negedge clock);
    drive(0, 1'b0, s, d, c);
    n = 0;
    while (!(we0 && addr0 == d + 32'd4) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rst_reach_word2", 64'(n < 50), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_ctrl", 64'({busy0, done0, error0, re0, we0, be0}), 64'd0);
    chk("rst_async_bus", {addr0, wd0}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    mdata[0][d[11:2]] = text_mem[s[11:2]];
    @(negedge clock);
    mem_cmp(0, "rst_partial_memory");
    run_cmd("after_reset", 0, s, d, c, 1'b0);

    run_cmd("start_while_busy", 0, TEXT_BEGIN + 32'h100, DATA_BEGIN + 32'h600, CB'(5), 1'b1);

    gmode = 2'd2;
    for (int it = 0; it < 40; it++) begin
      s = rand_addr($urandom_range(0, 1) == 1);
      d = rand_addr($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 9) == 0) ? CB'($urandom_range(1025, 3000))
                                      : CB'($urandom_range(0, 6));
      run_cmd("random", it % 2, s, d, c, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_bus_copy_engine.md
Name: memory_bus_copy_engine

Overview:
- Bus initiator for the combined text/data memory bus; the other end of the address / read_enable / write_enable / byte_enable / write_data / read_data interface.
- Copies a block of 32-bit words from a source region (text or data) to a destination region (data only).
- Sits beside the core and shares the bus through a single bus_grant input from the top-level mux.
- Used for boot-time .data initialisation and for test fixtures.

Parameters:
- COUNT_BITS, 16, width of the word-count field; a single command copies at most 2^COUNT_BITS-1 words.
- READ_LATENCY, 0, cycles from address/read_enable to valid read_data. Legal values are 0 and 1; any other value is a synthesis-time error.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- src_addr  input  32  source byte address of the first word.
- dst_addr  input  32  destination byte address of the first word.
- word_count  input  COUNT_BITS  number of words to copy.
- busy  output  1  high from the cycle after an accepted start until done/error is asserted.
- done  output  1  one-cycle pulse when the copy completes.
- error  output  1  one-cycle pulse when a command is rejected.
- bus_grant  input  1  engine may drive the bus this cycle.
- address  output  32  bus address.
- read_enable  output  1  bus read request.
- write_enable  output  1  bus write request.
- byte_enable  output  4  bus byte lanes.
- write_data  output  32  bus write data.
- read_data  input  32  bus read return.

Behaviour:
- Interface decision: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset (asynchronous, any state, including mid-copy):
  - FSM goes to IDLE.
  - busy, done, error, read_enable, write_enable = 0; byte_enable = 4'b0000; address = 0; write_data = 0.
  - Internal src, dst, remaining and data buffer clear to 0.
  - A partially completed copy is abandoned; no further bus cycles occur.
- States: IDLE, CHECK, READ, WAIT (present only when READ_LATENCY=1), WRITE, DONE, ERR.
- IDLE:
  - Bus outputs are at their reset values.
  - start=1 latches src_addr, dst_addr and word_count, then goes to CHECK.
- CHECK (1 cycle, busy=1, no bus activity). Go to ERR if any of the following hold:
  - src_addr[1:0] != 0 or dst_addr[1:0] != 0;
  - the destination range dst .. dst+4*count-1 is not entirely within DATA_BEGIN..DATA_END;
  - the source range is not entirely within TEXT_BEGIN..TEXT_END, and not entirely within DATA_BEGIN..DATA_END.
  - Range ends are computed in 34 bits so that 32-bit wrap-around is detected and rejected.
  - Otherwise, count == 0 goes to DONE; else goes to READ.
- READ:
  - Drive address = src and read_enable = 1, but only while bus_grant=1; with bus_grant=0 both enables are 0 and the state holds.
  - READ_LATENCY=0: on a granted cycle, capture read_data into the buffer and go to WRITE.
  - READ_LATENCY=1: on a granted cycle, go to WAIT.
- WAIT:
  - Hold address = src and read_enable = 1 while granted.
  - On a granted cycle, capture read_data and go to WRITE.
  - Loss of grant stalls the state; the capture occurs on the next granted cycle.
- WRITE:
  - While granted, drive address = dst, write_enable = 1, byte_enable = 4'b1111, write_data = buffer.
  - On a granted cycle: src += 4, dst += 4, remaining -= 1. If remaining was 1, go to DONE; else go to READ.
  - Not granted: all enables 0 and the state holds.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- ERR: error=1 and busy=0 for one cycle, then IDLE. No bus cycle is ever issued for a rejected command.
- start while busy, DONE or ERR is ignored; it is not queued.
- read_enable and write_enable are never high in the same cycle.
- byte_enable is 0 whenever write_enable is 0.
- Throughput at full grant: 2 cycles/word (READ_LATENCY=0) or 3 cycles/word (READ_LATENCY=1), plus 1 CHECK cycle and 1 DONE cycle.
- Counter arithmetic is unsigned, width COUNT_BITS. Address increments are 32-bit; range checking guarantees they never wrap.

Decomposition:
- Shared package (existing constants package):
  - TEXT_BEGIN, TEXT_END, DATA_BEGIN, DATA_END;
  - the copy-engine state enum (typedef);
  - WORD_BYTES = 4 and BYTE_ENABLE_WORD = 4'b1111.
- One sub-module, memory_bus_range_check: a combinational check of base/count against the text and data windows, returning src_ok and dst_ok. It is reused later by the core's load/store fault logic.
- The FSM, counters and data buffer stay in the top module.

Test Plan:
- Basic copy (READ_LATENCY=0, grant tied 1): text TEXT_BEGIN holds 0x11111111/0x22222222/0x33333333, src=TEXT_BEGIN, dst=DATA_BEGIN+0x10, count=3 -> data words match; done pulses exactly at cycle 1+6+1 after start; busy is high for 7 cycles.
- Grant stalls: the same copy with bus_grant low on alternate cycles -> identical memory contents; enables are never high while grant=0; done occurs later by the number of denied cycles.
- Rejects: src=DATA_BEGIN+2 -> error pulses 2 cycles after start, no read_enable/write_enable ever asserted; dst=TEXT_BEGIN -> error; dst=DATA_END-3 with count=2 -> error; count=0 -> done with no bus activity.
- READ_LATENCY=1 build: copy of 4 words -> 3 cycles/word; read_data is captured in WAIT, not READ; a model that returns 0xDEADBEEF in the READ cycle never appears in the destination.
- Reset mid-copy: assert reset_n=0 during the WRITE of word 2 of 5 -> all outputs return to 0 immediately (asynchronously); words 3..5 stay untouched; a new command afterwards completes normally.
- Start while busy: a second start with different addresses during a copy -> ignored; only the first command's destination is modified; exactly one done pulse.
